rt_imem_responder: RTL and testbench

- ROM-side responder for the RT-Core instruction fetch path. It serves the rom_req / rom_addr / rom_data / rom_ready fill protocol issued by rt_icache_controller.
- It is backed by a synchronous single-port instruction BRAM with 1-cycle read latency.
- It adds programmable wait states to model slow boot memory.
- It prefetches the next sequential word into a one-entry buffer, so that sequential line fills are served faster.
- It flags out-of-range fetches.

---
 rtl/rt_imem_responder_if.sv | 30 +++
 rtl/rt_imem_responder.sv | 258 +++++++++++++++++++++++++
 tb/tb_rt_imem_responder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rt_imem_responder_if.sv
// rt_imem_responder_if: fill-protocol bundle between the icache controller (master) and the
// instruction ROM responder (slave).
//   rom_req   master->slave  fetch request level
//   rom_addr  master->slave  16-bit word address
//   rom_data  slave->master  fetched word, held between responses
//   rom_ready slave->master  single-cycle response strobe
//   rom_err   slave->master  out-of-range flag, qualified by rom_ready
interface rt_imem_responder_if;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        rom_ready;
  logic        rom_err;

  modport master (
    output rom_req,
    output rom_addr,
    input  rom_data,
    input  rom_ready,
    input  rom_err
  );

  modport slave (
    input  rom_req,
    input  rom_addr,
    output rom_data,
    output rom_ready,
    output rom_err
  );
endinterface

// File: rtl/rt_imem_responder.sv
// rt_imem_responder: ROM-side responder for the RT-Core instruction fetch path. Serves fills
// from a 1-cycle-latency instruction BRAM, inserts programmable wait states, prefetches the next
// sequential word into a one-entry buffer and flags out-of-range fetches.
// Ports:
//   clk_rt_50mhz, rst_n    clock, asynchronous active-low reset
//   rom                    fill protocol (slave side of rt_imem_responder_if)
//   wait_cfg               extra wait states, sampled at accept
//   pf_flush               invalidate prefetch buffer / abort in-flight prefetch
//   mem_en/addr/rdata      BRAM read port
//   busy                   high outside IDLE/HOLD
//   stat_reads/pf_hits     saturating response / buffer-hit counters
module rt_imem_responder #(
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned ADDR_W      = 12,
  parameter bit          PREFETCH_EN = 1'b1,
  parameter logic [15:0] ERR_DATA    = 16'h0000
) (
  input  logic                  clk_rt_50mhz,
  input  logic                  rst_n,
  rt_imem_responder_if.slave    rom,
  input  logic [3:0]            wait_cfg,
  input  logic                  pf_flush,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [15:0]           mem_rdata,
  output logic                  busy,
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_pf_hits
);

  // StResp: answer next edge (buffer hit or out-of-range). StPf*: background prefetch.
  typedef enum logic [3:0] {
    StIdle, StWait, StRead, StData, StResp, StHold, StPfWait, StPfRead, StPfData
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d, w_q, w_d;
  logic [15:0]         req_addr_q, req_addr_d, last_addr_q, last_addr_d;
  logic                held_q, held_d, pend_q, pend_d, resp_err_q, resp_err_d;
  logic                buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0]   buf_tag_q, buf_tag_d, pf_addr_q, pf_addr_d, mem_addr_q, mem_addr_d;
  logic [15:0]         buf_data_q, buf_data_d, rom_data_q, rom_data_d;
  logic                rom_ready_q, rom_ready_d, rom_err_q, rom_err_d;
  logic                mem_en_q, mem_en_d, busy_q, busy_d;
  logic [31:0]         stat_reads_q, stat_reads_d, stat_pf_hits_q, stat_pf_hits_d;

  logic                acc, acc_oor, nxt_in_range, do_accept, allow_hit, pend_now;
  logic                respond, resp_err, resp_hit;
  logic [15:0]         resp_data;
  logic [ADDR_W-1:0]   nxt_addr;

  // A held request that was already answered (same address, never dropped) is not a new fetch.
  assign acc          = rom.rom_req && !(held_q && (rom.rom_addr == last_addr_q));
  assign acc_oor      = 32'(rom.rom_addr) >= DEPTH;
  assign nxt_in_range = (32'(req_addr_q) + 32'd1) < DEPTH;
  assign nxt_addr     = req_addr_q[ADDR_W-1:0] + ADDR_W'(1);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    w_d            = w_q;
    req_addr_d     = req_addr_q;
    last_addr_d    = last_addr_q;
    held_d         = held_q;
    pend_d         = pend_q;
    resp_err_d     = resp_err_q;
    buf_valid_d    = buf_valid_q;
    buf_tag_d      = buf_tag_q;
    buf_data_d     = buf_data_q;
    pf_addr_d      = pf_addr_q;
    mem_addr_d     = mem_addr_q;
    rom_data_d     = rom_data_q;
    rom_err_d      = rom_err_q;
    rom_ready_d    = 1'b0;
    stat_reads_d   = stat_reads_q;
    stat_pf_hits_d = stat_pf_hits_q;
    do_accept      = 1'b0;
    allow_hit      = 1'b0;
    pend_now       = 1'b0;
    respond        = 1'b0;
    resp_err       = 1'b0;
    resp_hit       = 1'b0;
    resp_data      = '0;

    if (!rom.rom_req) held_d = 1'b0;
    if (pf_flush) buf_valid_d = 1'b0;

    unique case (state_q)
      StIdle, StHold: begin
        if (acc) begin
          do_accept = 1'b1;
          allow_hit = !pf_flush;  // flush on the accept edge forces the miss path
        end
      end
      StWait: begin
        if (!rom.rom_req) state_d = StIdle;
        else if (cnt_q == 4'd1) begin
          state_d    = StRead;
          mem_addr_d = req_addr_q[ADDR_W-1:0];
        end else cnt_d = cnt_q - 4'd1;
      end
      StRead: state_d = rom.rom_req ? StData : StIdle;
      StData: begin
        if (!rom.rom_req) state_d = StIdle;
        else begin
          respond   = 1'b1;
          resp_data = mem_rdata;
        end
      end
      StResp: begin
        // Data comes from the buffer register, so a flush here cannot corrupt the reply.
        respond   = 1'b1;
        resp_err  = resp_err_q;
        resp_hit  = !resp_err_q;
        resp_data = resp_err_q ? ERR_DATA : buf_data_q;
      end
      StPfWait, StPfRead, StPfData: begin
        if (pf_flush) begin
          pend_d  = 1'b0;
          state_d = StHold;
          if (acc) do_accept = 1'b1;
        end else begin
          pend_now = pend_q && rom.rom_req;
          if (!pend_q && acc) begin
            if (!acc_oor && (32'(rom.rom_addr) == 32'(pf_addr_q))) begin
              // Request for the word being prefetched: answer once it lands.
              pend_now   = 1'b1;
              req_addr_d = rom.rom_addr;
              w_d        = wait_cfg;
            end else do_accept = 1'b1;
          end
          if (!do_accept) begin
            pend_d = pend_now;
            case (state_q)
              StPfWait: begin
                if (cnt_q == 4'd1) begin
                  state_d    = StPfRead;
                  mem_addr_d = pf_addr_q;
                end else cnt_d = cnt_q - 4'd1;
              end
              StPfRead: state_d = StPfData;
              default: begin
                buf_valid_d = 1'b1;
                buf_tag_d   = pf_addr_q;
                buf_data_d  = mem_rdata;
                pend_d      = 1'b0;
                if (pend_now) begin
                  state_d    = StResp;
                  resp_err_d = 1'b0;
                end else state_d = StHold;
              end
            endcase
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_accept) begin
      req_addr_d = rom.rom_addr;
      w_d        = wait_cfg;
      pend_d     = 1'b0;
      if (acc_oor) begin
        state_d    = StResp;
        resp_err_d = 1'b1;
      end else if (allow_hit && buf_valid_q && (rom.rom_addr[ADDR_W-1:0] == buf_tag_q)) begin
        state_d    = StResp;
        resp_err_d = 1'b0;
      end else if (wait_cfg == 4'd0) begin
        state_d    = StRead;
        mem_addr_d = rom.rom_addr[ADDR_W-1:0];
      end else begin
        state_d = StWait;
        cnt_d   = wait_cfg;
      end
    end

    if (respond) begin
      rom_ready_d = 1'b1;
      rom_data_d  = resp_data;
      rom_err_d   = resp_err;
      last_addr_d = req_addr_q;
      held_d      = 1'b1;
      if (stat_reads_q != 32'hFFFF_FFFF) stat_reads_d = stat_reads_q + 32'd1;
      if (resp_hit && (stat_pf_hits_q != 32'hFFFF_FFFF)) stat_pf_hits_d = stat_pf_hits_q + 32'd1;
      if (!resp_err && PREFETCH_EN && nxt_in_range) begin
        pf_addr_d   = nxt_addr;
        buf_valid_d = 1'b0;
        if (w_q == 4'd0) begin
          state_d    = StPfRead;
          mem_addr_d = nxt_addr;
        end else begin
          state_d = StPfWait;
          cnt_d   = w_q;
        end
      end else state_d = StHold;
    end

    mem_en_d = (state_d == StRead) || (state_d == StPfRead);
    busy_d   = (state_d != StIdle) && (state_d != StHold);
  end

  always_ff @(posedge clk_rt_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      w_q            <= '0;
      req_addr_q     <= '0;
      last_addr_q    <= '0;
      held_q         <= 1'b0;
      pend_q         <= 1'b0;
      resp_err_q     <= 1'b0;
      buf_valid_q    <= 1'b0;
      buf_tag_q      <= '0;
      buf_data_q     <= '0;
      pf_addr_q      <= '0;
      mem_addr_q     <= '0;
      rom_data_q     <= '0;
      rom_err_q      <= 1'b0;
      rom_ready_q    <= 1'b0;
      mem_en_q       <= 1'b0;
      busy_q         <= 1'b0;
      stat_reads_q   <= '0;
      stat_pf_hits_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      w_q            <= w_d;
      req_addr_q     <= req_addr_d;
      last_addr_q    <= last_addr_d;
      held_q         <= held_d;
      pend_q         <= pend_d;
      resp_err_q     <= resp_err_d;
      buf_valid_q    <= buf_valid_d;
      buf_tag_q      <= buf_tag_d;
      buf_data_q     <= buf_data_d;
      pf_addr_q      <= pf_addr_d;
      mem_addr_q     <= mem_addr_d;
      rom_data_q     <= rom_data_d;
      rom_err_q      <= rom_err_d;
      rom_ready_q    <= rom_ready_d;
      mem_en_q       <= mem_en_d;
      busy_q         <= busy_d;
      stat_reads_q   <= stat_reads_d;
      stat_pf_hits_q <= stat_pf_hits_d;
    end
  end

  assign rom.rom_data  = rom_data_q;
  assign rom.rom_ready = rom_ready_q;
  assign rom.rom_err   = rom_err_q;
  assign mem_en        = mem_en_q;
  assign mem_addr      = mem_addr_q;
  assign busy          = busy_q;
  assign stat_reads    = stat_reads_q;
  assign stat_pf_hits  = stat_pf_hits_q;

endmodule

// File: tb/tb_rt_imem_responder.sv
// Directed bench for rt_imem_responder. Backing memory holds mem[k] = k + 16'h1000.
module tb_rt_imem_responder;

  logic        clk_rt_50mhz = 1'b0;
  logic        rst_n;
  logic [3:0]  wait_cfg;
  logic        pf_flush;
  logic        mem_en;
  logic [11:0] mem_addr;
  logic [15:0] mem_rdata = '0;
  logic        busy;
  logic [31:0] stat_reads, stat_pf_hits;

  rt_imem_responder_if rom_if ();

  rt_imem_responder #(
    .DEPTH      (4096),
    .ADDR_W     (12),
    .PREFETCH_EN(1'b1),
    .ERR_DATA   (16'h0000)
  ) dut (
    .clk_rt_50mhz(clk_rt_50mhz),
    .rst_n       (rst_n),
    .rom         (rom_if.slave),
    .wait_cfg    (wait_cfg),
    .pf_flush    (pf_flush),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .stat_reads  (stat_reads),
    .stat_pf_hits(stat_pf_hits)
  );

  always #10 clk_rt_50mhz = ~clk_rt_50mhz;

  // Synchronous BRAM model, 1-cycle read latency.
  always @(posedge clk_rt_50mhz) begin
    if (mem_en) mem_rdata <= 16'h1000 + {4'h0, mem_addr};
  end

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_reads = 0;
  int          exp_hits = 0;
  int          mem_en_seen;
  int          pulses;
  logic [31:0] saved_reads;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one fetch, push the expected reply, then pop and compare when rom_ready appears.
  task automatic issue(input string tag, input logic [15:0] addr, input logic [3:0] w,
                       input logic flush, input int lat_exp, input logic [15:0] data_exp,
                       input logic err_exp, input logic hit);
    exp_t e;
    int   lat;
    bit   got;
    e.data = data_exp;
    e.err  = err_exp;
    e.lat  = lat_exp;
    sb_q.push_back(e);
    rom_if.rom_req  = 1'b1;
    rom_if.rom_addr = addr;
    wait_cfg        = w;
    pf_flush        = flush;
    lat             = 0;
    got             = 1'b0;
    mem_en_seen     = 0;
    while (!got && lat < 40) begin
      @(negedge clk_rt_50mhz);
      pf_flush = 1'b0;
      if (mem_en) mem_en_seen++;
      if (rom_if.rom_ready) got = 1'b1;
      else lat++;
    end
    rom_if.rom_req = 1'b0;
    e = sb_q.pop_front();
    if (got) begin
      exp_reads++;
      if (hit) exp_hits++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(e.lat));
    chk({tag, " data"}, {16'h0, rom_if.rom_data}, {16'h0, e.data});
    chk({tag, " err"}, {31'h0, rom_if.rom_err}, {31'h0, e.err});
    chk({tag, " stat_reads"}, stat_reads, 32'(exp_reads));
    chk({tag, " stat_pf_hits"}, stat_pf_hits, 32'(exp_hits));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk_rt_50mhz);
    while (busy && n < 60) begin
      @(negedge clk_rt_50mhz);
      n++;
    end
    chk({tag, " idle"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    rom_if.rom_req  = 1'b0;
    rom_if.rom_addr = '0;
    wait_cfg        = '0;
    pf_flush        = 1'b0;
    repeat (3) @(negedge clk_rt_50mhz);
    chk("reset rom_data", {16'h0, rom_if.rom_data}, 32'h0);
    chk("reset ready/err/mem_en/busy",
        {28'h0, rom_if.rom_ready, rom_if.rom_err, mem_en, busy}, 32'h0);
    chk("reset mem_addr", {20'h0, mem_addr}, 32'h0);
    chk("reset stats", stat_reads | stat_pf_hits, 32'h0);
    rst_n = 1'b1;
    @(negedge clk_rt_50mhz);

    // Miss latency, W=0.
    issue("miss w0", 16'h0100, 4'd0, 1'b0, 2, 16'h1100, 1'b0, 1'b0);
    @(negedge clk_rt_50mhz);
    chk("ready single pulse", {31'h0, rom_if.rom_ready}, 32'h0);
    chk("data held", {16'h0, rom_if.rom_data}, 32'h1100);

    // Wait-state latency.
    wait_idle("pre w5");
    issue("miss w5", 16'h0200, 4'd5, 1'b0, 7, 16'h1200, 1'b0, 1'b0);
    wait_idle("pre w15");
    issue("miss w15", 16'h0210, 4'd15, 1'b0, 17, 16'h1210, 1'b0, 1'b0);

    // Sequential prefetch chain.
    wait_idle("pre seq");
    issue("seq 0300", 16'h0300, 4'd3, 1'b0, 5, 16'h1300, 1'b0, 1'b0);
    wait_idle("seq land1");
    issue("seq 0301", 16'h0301, 4'd3, 1'b0, 1, 16'h1301, 1'b0, 1'b1);
    wait_idle("seq land2");
    issue("seq 0302", 16'h0302, 4'd3, 1'b0, 1, 16'h1302, 1'b0, 1'b1);

    // Abort during prefetch, flush vs hit, and a hit on an in-flight prefetch.
    wait_idle("pre abort");
    issue("abort base", 16'h0400, 4'd3, 1'b0, 5, 16'h1400, 1'b0, 1'b0);
    @(negedge clk_rt_50mhz);
    issue("abort miss", 16'h0800, 4'd3, 1'b0, 5, 16'h1800, 1'b0, 1'b0);
    wait_idle("pre flush");
    issue("flush wins", 16'h0801, 4'd3, 1'b1, 5, 16'h1801, 1'b0, 1'b0);
    @(negedge clk_rt_50mhz);
    issue("inflight hit", 16'h0802, 4'd3, 1'b0, 4, 16'h1802, 1'b0, 1'b1);

    // Out of range: 1-cycle error reply, no BRAM access.
    wait_idle("pre oor");
    issue("oor", 16'h1000, 4'd0, 1'b0, 1, 16'h0000, 1'b1, 1'b0);
    chk("oor mem_en", 32'(mem_en_seen), 32'h0);
    @(negedge clk_rt_50mhz);
    chk("oor err held", {30'h0, rom_if.rom_ready, rom_if.rom_err}, 32'h1);

    // Abandon during WAIT.
    saved_reads     = stat_reads;
    rom_if.rom_req  = 1'b1;
    rom_if.rom_addr = 16'h0250;
    wait_cfg        = 4'd4;
    repeat (2) @(negedge clk_rt_50mhz);
    rom_if.rom_req = 1'b0;
    pulses         = 0;
    repeat (10) begin
      @(negedge clk_rt_50mhz);
      if (rom_if.rom_ready) pulses++;
    end
    chk("abandon pulses", 32'(pulses), 32'h0);
    chk("abandon stat_reads", stat_reads, saved_reads);
    chk("abandon busy", {31'h0, busy}, 32'h0);

    // Reset in the middle of a WAIT clears everything including the buffer.
    issue("pre reset", 16'h0600, 4'd2, 1'b0, 4, 16'h1600, 1'b0, 1'b0);
    wait_idle("pre reset land");
    rom_if.rom_req  = 1'b1;
    rom_if.rom_addr = 16'h0700;
    wait_cfg        = 4'd4;
    repeat (2) @(negedge clk_rt_50mhz);
    chk("busy before reset", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid reset rom_data", {16'h0, rom_if.rom_data}, 32'h0);
    chk("mid reset ready/err/mem_en/busy",
        {28'h0, rom_if.rom_ready, rom_if.rom_err, mem_en, busy}, 32'h0);
    chk("mid reset mem_addr", {20'h0, mem_addr}, 32'h0);
    chk("mid reset stat_reads", stat_reads, 32'h0);
    chk("mid reset stat_pf_hits", stat_pf_hits, 32'h0);
    rom_if.rom_req = 1'b0;
    exp_reads      = 0;
    exp_hits       = 0;
    @(negedge clk_rt_50mhz);
    rst_n = 1'b1;
    @(negedge clk_rt_50mhz);
    issue("post reset miss", 16'h0601, 4'd2, 1'b0, 4, 16'h1601, 1'b0, 1'b0);

    // Held request: exactly one response.
    wait_idle("pre hold");
    rom_if.rom_req  = 1'b1;
    rom_if.rom_addr = 16'h0500;
    wait_cfg        = 4'd0;
    pulses          = 0;
    repeat (20) begin
      @(negedge clk_rt_50mhz);
      if (rom_if.rom_ready) pulses++;
    end
    rom_if.rom_req = 1'b0;
    exp_reads++;
    chk("hold pulses", 32'(pulses), 32'h1);
    chk("hold data", {16'h0, rom_if.rom_data}, 32'h1500);
    chk("hold stat_reads", stat_reads, 32'(exp_reads));
    chk("hold stat_pf_hits", stat_pf_hits, 32'(exp_hits));

    repeat (2) @(negedge clk_rt_50mhz);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
